// File: rtl/m2vcoefbuf_if.sv
//------------------------------------------------------------------------------
// m2vcoefbuf_if : coefficient pull / block read bus of the coefficient buffer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface m2vcoefbuf_if;
    logic        ready_coef;
    logic        block_start;
    logic        s2_enable;
    logic        s2_coded;
    logic        coef_sign;
    logic [11:0] coef_data;
    logic        coef_next;
    logic        blk_valid;
    logic        blk_coded;
    logic [5:0]  rd_addr;
    logic [11:0] rd_data;
    logic        blk_done;
    logic        ovf_err;

    modport slave (
        input  block_start, s2_enable, s2_coded, coef_sign, coef_data,
        input  rd_addr, blk_done,
        output ready_coef, coef_next, blk_valid, blk_coded, rd_data, ovf_err
    );

    modport master (
        output block_start, s2_enable, s2_coded, coef_sign, coef_data,
        output rd_addr, blk_done,
        input  ready_coef, coef_next, blk_valid, blk_coded, rd_data, ovf_err
    );
endinterface

`default_nettype wire

// File: rtl/m2vcoefbuf.sv
//------------------------------------------------------------------------------
// m2vcoefbuf : ping-pong 2x64 coefficient buffer between m2visdq and the IDCT
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module m2vcoefbuf #(
    parameter int START_LAT = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         softreset,
    m2vcoefbuf_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PULL = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_LAST = (START_LAT > 1) ? 3'(START_LAT - 2) : 3'd0;

    state_t       state, state_nxt;
    logic         wr_bank, rd_bank;
    logic [1:0]   full, coded;
    logic [2:0]   wait_cnt;
    logic [5:0]   coef_cnt;
    logic         ovf_err;
    logic [11:0]  rd_data;
    logic [11:0]  mem [0:127];

    logic         ready, accept, start_coded, start_uncoded, pull_last, release_ok;
    logic [1:0]   set_mask, clr_mask;
    logic signed [12:0] conv_wide;
    logic [11:0]  conv;

    always_comb begin
        ready         = (state == ST_IDLE) && !full[wr_bank];
        accept        = bus.block_start && ready;
        start_coded   = accept && bus.s2_enable && bus.s2_coded;
        start_uncoded = accept && bus.s2_enable && !bus.s2_coded;
        pull_last     = (state == ST_PULL) && (coef_cnt == 6'd63);
        release_ok    = bus.blk_done && full[rd_bank];
        set_mask      = (start_uncoded || pull_last) ? (2'b01 << wr_bank) : 2'b00;
        clr_mask      = release_ok ? (2'b01 << rd_bank) : 2'b00;
        state_nxt     = state;
        case (state)
            ST_IDLE: if (start_coded) state_nxt = (START_LAT <= 1) ? ST_PULL : ST_WAIT;
            ST_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = ST_PULL;
            ST_PULL: if (pull_last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sign-magnitude to two's complement; only +4095..+2048 and -4095..-2049 saturate.
    always_comb begin
        conv_wide = bus.coef_sign ? -$signed({1'b0, bus.coef_data})
                                  :  $signed({1'b0, bus.coef_data});
        if (conv_wide > 13'sd2047)
            conv = 12'h7FF;
        else if (conv_wide < -13'sd2048)
            conv = 12'h800;
        else
            conv = conv_wide[11:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full     <= 2'b00;
            coded    <= 2'b00;
            wait_cnt <= 3'd0;
            coef_cnt <= 6'd0;
            ovf_err  <= 1'b0;
            rd_data  <= 12'd0;
        end else if (softreset) begin
            state    <= ST_IDLE;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full     <= 2'b00;
            coded    <= 2'b00;
            wait_cnt <= 3'd0;
            coef_cnt <= 6'd0;
            ovf_err  <= 1'b0;
            rd_data  <= 12'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 3'd1 : 3'd0;
            coef_cnt <= (state == ST_PULL) ? coef_cnt + 6'd1 : 6'd0;
            full     <= (full | set_mask) & ~clr_mask;
            if (start_uncoded || pull_last) begin
                wr_bank        <= ~wr_bank;
                coded[wr_bank] <= pull_last;
            end
            if (release_ok)
                rd_bank <= ~rd_bank;
            if (bus.block_start && !ready)
                ovf_err <= 1'b1;
            // Uncoded banks keep stale contents, so the coded flag forces zero.
            rd_data  <= coded[rd_bank] ? mem[{rd_bank, bus.rd_addr}] : 12'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_PULL)
            mem[{wr_bank, coef_cnt}] <= conv;
    end

    assign bus.ready_coef = ready;
    assign bus.coef_next  = (state == ST_PULL);
    assign bus.blk_valid  = full[rd_bank];
    assign bus.blk_coded  = coded[rd_bank];
    assign bus.rd_data    = rd_data;
    assign bus.ovf_err    = ovf_err;

endmodule

`default_nettype wire

// File: tb/tb_m2vcoefbuf.sv
//------------------------------------------------------------------------------
// tb_m2vcoefbuf : scoreboard bench for the ping-pong coefficient buffer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_m2vcoefbuf;

    logic clk = 1'b0;
    logic reset_n;
    logic softreset;

    m2vcoefbuf_if bus();

    m2vcoefbuf #(.START_LAT(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .softreset (softreset),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Upstream model: presents coefficient src_idx, advances on coef_next.
    logic [11:0] src_mag  [64];
    logic        src_sign [64];
    logic [5:0]  src_idx;
    logic [11:0] sb [$];
    int checks = 0;
    int passes = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)           src_idx <= 6'd0;
        else if (softreset)     src_idx <= 6'd0;
        else if (bus.coef_next) src_idx <= src_idx + 6'd1;
    end

    assign bus.coef_data = src_mag[src_idx];
    assign bus.coef_sign = src_sign[src_idx];

    function automatic logic [11:0] model(input logic s, input logic [11:0] m);
        int v;
        v = s ? -int'(m) : int'(m);
        if (v > 2047)  v = 2047;
        if (v < -2048) v = -2048;
        return 12'(v);
    endfunction

    task automatic fill(input int kind, input bit push);
        for (int i = 0; i < 64; i++) begin
            case (kind)
                0: begin src_mag[i] = 12'(i); src_sign[i] = (i % 2) == 1; end
                1: begin
                    case (i)
                        0: begin src_mag[i] = 12'd4095; src_sign[i] = 1'b0; end
                        1: begin src_mag[i] = 12'd4095; src_sign[i] = 1'b1; end
                        2: begin src_mag[i] = 12'd0;    src_sign[i] = 1'b1; end
                        3: begin src_mag[i] = 12'd2048; src_sign[i] = 1'b0; end
                        4: begin src_mag[i] = 12'd2048; src_sign[i] = 1'b1; end
                        5: begin src_mag[i] = 12'd2049; src_sign[i] = 1'b1; end
                        default: begin
                            src_mag[i]  = 12'($urandom_range(0, 4095));
                            src_sign[i] = 1'($urandom_range(0, 1));
                        end
                    endcase
                end
                default: begin src_mag[i] = 12'(i * 37 + 5); src_sign[i] = (i % 3) == 0; end
            endcase
            if (push) sb.push_back(model(src_sign[i], src_mag[i]));
        end
    endtask

    task automatic pulse_start(input logic en, input logic cd);
        @(negedge clk);
        bus.block_start = 1'b1; bus.s2_enable = en; bus.s2_coded = cd;
        @(negedge clk);
        bus.block_start = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); bus.blk_done = 1'b1;
        @(negedge clk); bus.blk_done = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.blk_valid) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.coef_next !== 1'b0)  $display("FAIL rst_coef_next got %b want 0", bus.coef_next); else passes++;
        checks++; if (bus.ready_coef !== 1'b1) $display("FAIL rst_ready got %b want 1", bus.ready_coef); else passes++;
        checks++; if (bus.blk_valid !== 1'b0)  $display("FAIL rst_blk_valid got %b want 0", bus.blk_valid); else passes++;
        checks++; if (bus.blk_coded !== 1'b0)  $display("FAIL rst_blk_coded got %b want 0", bus.blk_coded); else passes++;
        checks++; if (bus.rd_data !== 12'd0)   $display("FAIL rst_rd_data got %0d want 0", bus.rd_data); else passes++;
        checks++; if (bus.ovf_err !== 1'b0)    $display("FAIL rst_ovf got %b want 0", bus.ovf_err); else passes++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_coded();
        int first = -1, cnt = 0, vk = -1;
        logic [11:0] exp;
        fill(0, 1'b1);
        @(negedge clk);
        bus.block_start = 1'b1; bus.s2_enable = 1'b1; bus.s2_coded = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.block_start = 1'b0;
                checks++; if (bus.ready_coef !== 1'b0) $display("FAIL coded_ready_drop got %b want 0", bus.ready_coef); else passes++;
            end
            if (bus.coef_next) begin cnt++; if (first < 0) first = k; end
            if (bus.blk_valid && vk < 0) vk = k;
        end
        checks++; if (first != 2)  $display("FAIL coded_first_next got %0d want 2", first); else passes++;
        checks++; if (cnt != 64)   $display("FAIL coded_next_count got %0d want 64", cnt); else passes++;
        checks++; if (vk != 66)    $display("FAIL coded_valid_cycle got %0d want 66", vk); else passes++;
        checks++; if (bus.blk_coded !== 1'b1)  $display("FAIL coded_blk_coded got %b want 1", bus.blk_coded); else passes++;
        checks++; if (bus.ready_coef !== 1'b1) $display("FAIL coded_ready_back got %b want 1", bus.ready_coef); else passes++;
        for (int a = 0; a < 64; a++) begin
            bus.rd_addr = 6'(a);
            @(negedge clk);
            exp = (sb.size() > 0) ? sb.pop_front() : 12'hXXX;
            checks++; if (bus.rd_data !== exp) $display("FAIL coded_rd[%0d] got %0d want %0d", a, $signed(bus.rd_data), $signed(exp)); else passes++;
        end
        pulse_done();
        checks++; if (bus.blk_valid !== 1'b0) $display("FAIL coded_release got %b want 0", bus.blk_valid); else passes++;
    endtask

    task automatic test_saturation();
        bit ok;
        logic [11:0] exp;
        fill(1, 1'b1);
        pulse_start(1'b1, 1'b1);
        wait_valid(ok);
        checks++; if (!ok) $display("FAIL sat_valid_timeout got 0 want 1"); else passes++;
        for (int a = 0; a < 64; a++) begin
            bus.rd_addr = 6'(a);
            @(negedge clk);
            exp = (sb.size() > 0) ? sb.pop_front() : 12'hXXX;
            checks++; if (bus.rd_data !== exp) $display("FAIL sat_rd[%0d] got %0d want %0d", a, $signed(bus.rd_data), $signed(exp)); else passes++;
        end
        pulse_done();
    endtask

    task automatic test_uncoded();
        int hi = 0;
        pulse_start(1'b1, 1'b0);
        checks++; if (bus.blk_valid !== 1'b1)  $display("FAIL unc_valid got %b want 1", bus.blk_valid); else passes++;
        checks++; if (bus.blk_coded !== 1'b0)  $display("FAIL unc_coded got %b want 0", bus.blk_coded); else passes++;
        checks++; if (bus.ready_coef !== 1'b1) $display("FAIL unc_ready got %b want 1", bus.ready_coef); else passes++;
        pulse_start(1'b0, 1'b1);
        for (int k = 0; k < 70; k++) begin
            if (bus.coef_next) hi++;
            @(negedge clk);
        end
        checks++; if (hi != 0) $display("FAIL dis_coef_next got %0d want 0", hi); else passes++;
        checks++; if (bus.ready_coef !== 1'b1) $display("FAIL dis_ready got %b want 1", bus.ready_coef); else passes++;
        checks++; if (bus.ovf_err !== 1'b0)    $display("FAIL dis_ovf got %b want 0", bus.ovf_err); else passes++;
        for (int a = 0; a < 64; a++) sb.push_back(12'd0);
        for (int a = 0; a < 64; a++) begin
            bus.rd_addr = 6'(a);
            @(negedge clk);
            checks++; if (bus.rd_data !== sb.pop_front()) $display("FAIL unc_rd[%0d] got %0d want 0", a, $signed(bus.rd_data)); else passes++;
        end
        pulse_done();
        checks++; if (bus.blk_valid !== 1'b0) $display("FAIL unc_release got %b want 0 (other bank must be empty)", bus.blk_valid); else passes++;
    endtask

    task automatic test_overflow();
        bit ok;
        int hi = 0;
        logic [11:0] exp;
        fill(0, 1'b1);
        pulse_start(1'b1, 1'b1);
        wait_valid(ok);
        checks++; if (!ok) $display("FAIL ovf_first_timeout got 0 want 1"); else passes++;
        fill(2, 1'b1);
        pulse_start(1'b1, 1'b1);
        repeat (70) @(negedge clk);
        checks++; if (bus.ready_coef !== 1'b0) $display("FAIL ovf_ready_full got %b want 0", bus.ready_coef); else passes++;
        pulse_start(1'b1, 1'b1);
        checks++; if (bus.ovf_err !== 1'b1) $display("FAIL ovf_err_set got %b want 1", bus.ovf_err); else passes++;
        for (int k = 0; k < 10; k++) begin
            if (bus.coef_next) hi++;
            @(negedge clk);
        end
        checks++; if (hi != 0) $display("FAIL ovf_dropped_next got %0d want 0", hi); else passes++;
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 64; a++) begin
                bus.rd_addr = 6'(a);
                @(negedge clk);
                exp = (sb.size() > 0) ? sb.pop_front() : 12'hXXX;
                checks++; if (bus.rd_data !== exp) $display("FAIL ovf_rd%0d[%0d] got %0d want %0d", b, a, $signed(bus.rd_data), $signed(exp)); else passes++;
            end
            pulse_done();
            checks++; if (bus.ready_coef !== 1'b1) $display("FAIL ovf_ready_after_done%0d got %b want 1", b, bus.ready_coef); else passes++;
            checks++; if (bus.blk_valid !== (b == 0)) $display("FAIL ovf_valid_after_done%0d got %b want %b", b, bus.blk_valid, b == 0); else passes++;
        end
        checks++; if (bus.ovf_err !== 1'b1) $display("FAIL ovf_sticky got %b want 1", bus.ovf_err); else passes++;
    endtask

    task automatic test_same_cycle();
        bit ok;
        logic [11:0] exp;
        fill(0, 1'b1);
        pulse_start(1'b1, 1'b1);
        wait_valid(ok);
        checks++; if (!ok) $display("FAIL same_first_timeout got 0 want 1"); else passes++;
        for (int a = 0; a < 64; a++) begin
            bus.rd_addr = 6'(a);
            @(negedge clk);
            exp = (sb.size() > 0) ? sb.pop_front() : 12'hXXX;
            checks++; if (bus.rd_data !== exp) $display("FAIL same_rdA[%0d] got %0d want %0d", a, $signed(bus.rd_data), $signed(exp)); else passes++;
        end
        fill(2, 1'b1);
        @(negedge clk);
        bus.block_start = 1'b1; bus.s2_enable = 1'b1; bus.s2_coded = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (k == 1) bus.block_start = 1'b0;
            if (k == 65) begin
                checks++; if (bus.coef_next !== 1'b1) $display("FAIL same_last_pull got %b want 1", bus.coef_next); else passes++;
                bus.blk_done = 1'b1;
            end
        end
        @(negedge clk);
        bus.blk_done = 1'b0;
        checks++; if (bus.blk_valid !== 1'b1)  $display("FAIL same_valid got %b want 1", bus.blk_valid); else passes++;
        checks++; if (bus.blk_coded !== 1'b1)  $display("FAIL same_coded got %b want 1", bus.blk_coded); else passes++;
        checks++; if (bus.ready_coef !== 1'b1) $display("FAIL same_ready got %b want 1", bus.ready_coef); else passes++;
        for (int a = 0; a < 64; a++) begin
            bus.rd_addr = 6'(a);
            @(negedge clk);
            exp = (sb.size() > 0) ? sb.pop_front() : 12'hXXX;
            checks++; if (bus.rd_data !== exp) $display("FAIL same_rdB[%0d] got %0d want %0d", a, $signed(bus.rd_data), $signed(exp)); else passes++;
        end
        pulse_done();
        checks++; if (bus.blk_valid !== 1'b0) $display("FAIL same_release got %b want 0", bus.blk_valid); else passes++;
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [11:0] exp;
        fill(0, 1'b0);
        pulse_start(1'b1, 1'b1);
        repeat (31) @(negedge clk);
        checks++; if (bus.coef_next !== 1'b1) $display("FAIL ar_pulling got %b want 1", bus.coef_next); else passes++;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.coef_next !== 1'b0)  $display("FAIL ar_coef_next got %b want 0", bus.coef_next); else passes++;
        checks++; if (bus.ready_coef !== 1'b1) $display("FAIL ar_ready got %b want 1", bus.ready_coef); else passes++;
        checks++; if (bus.blk_valid !== 1'b0)  $display("FAIL ar_valid got %b want 0", bus.blk_valid); else passes++;
        checks++; if (bus.blk_coded !== 1'b0)  $display("FAIL ar_coded got %b want 0", bus.blk_coded); else passes++;
        checks++; if (bus.rd_data !== 12'd0)   $display("FAIL ar_rd_data got %0d want 0", bus.rd_data); else passes++;
        checks++; if (bus.ovf_err !== 1'b0)    $display("FAIL ar_ovf got %b want 0", bus.ovf_err); else passes++;
        @(negedge clk);
        reset_n = 1'b1;
        fill(2, 1'b1);
        pulse_start(1'b1, 1'b1);
        wait_valid(ok);
        checks++; if (!ok) $display("FAIL ar_refill_timeout got 0 want 1"); else passes++;
        for (int a = 0; a < 64; a++) begin
            bus.rd_addr = 6'(a);
            @(negedge clk);
            exp = (sb.size() > 0) ? sb.pop_front() : 12'hXXX;
            checks++; if (bus.rd_data !== exp) $display("FAIL ar_rd[%0d] got %0d want %0d", a, $signed(bus.rd_data), $signed(exp)); else passes++;
        end
        pulse_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        softreset = 1'b0;
        bus.block_start = 1'b0;
        bus.s2_enable = 1'b0;
        bus.s2_coded = 1'b0;
        bus.rd_addr = 6'd0;
        bus.blk_done = 1'b0;
        for (int i = 0; i < 64; i++) begin src_mag[i] = 12'd0; src_sign[i] = 1'b0; end
        test_reset();
        test_coded();
        test_saturation();
        test_uncoded();
        test_overflow();
        test_same_cycle();
        test_async_reset();
        checks++; if (sb.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
